mem_program_loader: RTL and testbench
=====================================

MEM_PROGRAM_LOADER -- requirements
Module: mem_program_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-002 Parameter IW, default 24, meaning instruction/data word width in bits.
REQ-003 Parameter DEPTH, default 32, meaning instruction memory words; AW = clog2(DEPTH).
REQ-004 Parameter LOAD_BASE, default 0, meaning first memory address written in LOAD.
REQ-005 Parameter CLEAR_EN, default 1, meaning zero-fill the memory before loading (0 = skip).
REQ-006 Parameter MAX_CYCLES, default 100, meaning RUN cycles allowed before timeout.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 restart  in  1  single-cycle pulse; aborts the current operation and restarts the sequence.
REQ-010 in_valid  in  1  program word present; in_data  in  IW  program word; in_last  in  1  final word of the program.
REQ-011 in_ready  out  1  loader accepts in_data this cycle.
REQ-012 mem_we  out  1  memory write strobe; mem_addr  out  AW  write address; mem_wdata  out  IW  write data.
REQ-013 halt_in  in  1  core reports a halt instruction retired.
REQ-014 core_rst  out  1  holds the core (pc = 0) in reset; core_run  out  1  core clock enable.
REQ-015 done  out  1  halt seen; timeout  out  1  MAX_CYCLES exhausted; load_ovf  out  1  memory filled without in_last.
REQ-016 cycles  out  32  RUN cycle count; load_count  out  AW+1  words accepted.

Function
REQ-017 States SHALL be CLEAR, LOAD, RUN, DONE, TIMEOUT; the state register updates only on the rising edge of clk.
REQ-018 CLEAR: mem_we=1, mem_wdata=0, mem_addr = clear counter, counting 0..DEPTH-1 one per cycle; after address DEPTH-1 -> LOAD. DEPTH cycles total.
REQ-019 LOAD: in_ready=1; the handshake is in_valid && in_ready; the write is combinational in the same cycle: mem_we=1, mem_addr=LOAD_BASE+load_count, mem_wdata=in_data.
REQ-020 in_ready SHALL be 0 in every state other than LOAD; in_valid outside LOAD has no effect.
REQ-021 load_count increments per accepted word; accepted word with in_last=1 -> RUN next cycle.
REQ-022 Accepted word at address DEPTH-1 with in_last=0: the word is written, load_ovf=1 (sticky until reset/restart), and the next state is RUN.
REQ-023 No mem_we in RUN, DONE or TIMEOUT.
REQ-024 core_rst=1 in CLEAR and LOAD, 0 in RUN, DONE and TIMEOUT; core_run=1 only in RUN.
REQ-025 RUN: cycles increments every RUN cycle starting from 0; halt_in=1 -> DONE next cycle, done=1, cycles frozen.
REQ-026 RUN with cycles == MAX_CYCLES-1 and halt_in=0 -> TIMEOUT next cycle, timeout=1, cycles frozen at MAX_CYCLES.
REQ-027 If halt_in=1 and the timeout condition occur in the same cycle, halt SHALL win (DONE, timeout=0).
REQ-028 DONE and TIMEOUT are held until reset or restart.
REQ-029 restart in any state: next cycle enters CLEAR (LOAD if CLEAR_EN=0); the clear counter, load_count, cycles, done, timeout and load_ovf are zeroed; a handshake in that same cycle is still written.
REQ-030 All counters are unsigned; cycles saturates at 2^32-1 (reachable only if MAX_CYCLES is large).

Reset
REQ-031 reset=1 -> next cycle: state CLEAR (LOAD if CLEAR_EN=0), all counters 0, done=timeout=load_ovf=0, core_rst=1, core_run=0.
REQ-032 reset has priority over restart, handshake and halt_in; reset mid-CLEAR/LOAD/RUN aborts with no further writes.

Verification
REQ-033 Reset, CLEAR_EN=1, DEPTH=32 -> 32 cycles of mem_we with wdata=0 at addresses 0..31, then in_ready=1.
REQ-034 Load 9 words (last on word 9, LOAD_BASE=6, with in_valid gaps) -> writes at addresses 6..14 in order, load_count=9, core_rst falls the next cycle.
REQ-035 RUN, halt_in asserted on the 7th RUN cycle -> done=1, cycles=7, core_run=0, state held.
REQ-036 No halt, MAX_CYCLES=100 -> timeout=1 after exactly 100 RUN cycles; halt_in and timeout in the same cycle -> done=1, timeout=0.
REQ-037 DEPTH=8, LOAD_BASE=0, 8 words without in_last -> load_ovf=1, state RUN, no 9th handshake accepted.
REQ-038 restart pulse mid-RUN and reset mid-LOAD -> return to CLEAR with counters zeroed and no stray mem_we.

Source files
------------

// File: rtl/mem_program_loader.sv
// rtl/mem_program_loader.sv - clears instruction memory, streams a program into it, then runs the core until it halts or times out
module mem_program_loader #(
  parameter int unsigned IW         = 24,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned LOAD_BASE  = 0,
  parameter bit          CLEAR_EN   = 1'b1,
  parameter int unsigned MAX_CYCLES = 100,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [IW-1:0] mem_wdata,
  input  logic          halt_in,
  output logic          core_rst,
  output logic          core_run,
  output logic          done,
  output logic          timeout,
  output logic          load_ovf,
  output logic [31:0]   cycles,
  output logic [AW:0]   load_count
);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW:0]   LAST_W  = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]   BASE_W  = (AW + 1)'(LOAD_BASE);
  localparam logic [31:0]   MAX_M1  = 32'(MAX_CYCLES - 1);

  state_t        state_q, state_d;
  state_t        init_state;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          load_ovf_q, load_ovf_d;
  logic [AW:0]   load_addr;

  assign load_addr = BASE_W + load_cnt_q;

  always_comb begin
    init_state = S_LOAD;
    if (CLEAR_EN) begin
      init_state = S_CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= init_state;
      clr_cnt_q  <= '0;
      load_cnt_q <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      load_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      load_cnt_q <= load_cnt_d;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      load_ovf_q <= load_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    load_cnt_d = load_cnt_q;
    cycles_d   = cycles_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    load_ovf_d = load_ovf_q;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_rst   = 1'b0;
    core_run   = 1'b0;

    case (state_q)
      S_CLEAR: begin
        core_rst  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_A) begin
          clr_cnt_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        core_rst  = 1'b1;
        in_ready  = 1'b1;
        mem_addr  = load_addr[AW-1:0];
        mem_wdata = in_data;
        if (in_valid) begin
          mem_we     = 1'b1;
          load_cnt_d = load_cnt_q + 1'b1;
          if (in_last) begin
            state_d = S_RUN;
          end else if (load_addr == LAST_W) begin
            // Memory is full but the program never ended: run what we have.
            load_ovf_d = 1'b1;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        core_run = 1'b1;
        if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
        // Halt is tested first so it wins over a coincident timeout.
        if (halt_in) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cycles_q == MAX_M1) begin
          timeout_d = 1'b1;
          state_d   = S_TIMEOUT;
        end
      end
      S_DONE, S_TIMEOUT: begin
      end
      default: begin
        state_d = init_state;
      end
    endcase

    if (restart || reset) begin
      state_d    = init_state;
      clr_cnt_d  = '0;
      load_cnt_d = '0;
      cycles_d   = '0;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      load_ovf_d = 1'b0;
    end

    // A restart still lets this cycle's handshake land; reset does not.
    if (reset) begin
      in_ready = 1'b0;
      mem_we   = 1'b0;
    end
  end

  assign done       = done_q;
  assign timeout    = timeout_q;
  assign load_ovf   = load_ovf_q;
  assign cycles     = cycles_q;
  assign load_count = load_cnt_q;

endmodule

// File: tb/tb_mem_program_loader.sv
// tb/tb_mem_program_loader.sv - bench for mem_program_loader (32-word/base 6 instance and 8-word no-clear instance)
module tb_mem_program_loader;

  localparam int BA = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b1, a_restart = 1'b0, a_in_valid = 1'b0, a_in_last = 1'b0, a_halt_in = 1'b0;
  logic [23:0] a_in_data = '0;
  logic        a_in_ready, a_mem_we, a_core_rst, a_core_run, a_done, a_timeout, a_load_ovf;
  logic [4:0]  a_mem_addr;
  logic [23:0] a_mem_wdata;
  logic [31:0] a_cycles;
  logic [5:0]  a_load_count;

  logic        b_reset = 1'b1, b_restart = 1'b0, b_in_valid = 1'b0, b_in_last = 1'b0, b_halt_in = 1'b0;
  logic [23:0] b_in_data = '0;
  logic        b_in_ready, b_mem_we, b_core_rst, b_core_run, b_done, b_timeout, b_load_ovf;
  logic [2:0]  b_mem_addr;
  logic [23:0] b_mem_wdata;
  logic [31:0] b_cycles;
  logic [3:0]  b_load_count;

  mem_program_loader #(.IW(24), .DEPTH(32), .LOAD_BASE(BA), .CLEAR_EN(1'b1), .MAX_CYCLES(100)) dut_a (
    .clk(clk), .reset(a_reset), .restart(a_restart),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last), .in_ready(a_in_ready),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .halt_in(a_halt_in), .core_rst(a_core_rst), .core_run(a_core_run),
    .done(a_done), .timeout(a_timeout), .load_ovf(a_load_ovf),
    .cycles(a_cycles), .load_count(a_load_count)
  );

  mem_program_loader #(.IW(24), .DEPTH(8), .LOAD_BASE(0), .CLEAR_EN(1'b0), .MAX_CYCLES(10)) dut_b (
    .clk(clk), .reset(b_reset), .restart(b_restart),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last), .in_ready(b_in_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .halt_in(b_halt_in), .core_rst(b_core_rst), .core_run(b_core_run),
    .done(b_done), .timeout(b_timeout), .load_ovf(b_load_ovf),
    .cycles(b_cycles), .load_count(b_load_count)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [4:0] addr; logic [23:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_w;
  bit  mon_en = 1'b0;

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic        l;
    logic        exp_ready;
    logic [5:0]  exp_lc;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write on instance A must match the next expected write in order.
  always @(negedge clk) begin
    if (mon_en && a_mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_we actual addr=%0d data=%0h required=no write", a_mem_addr, a_mem_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", 32'(a_mem_addr), 32'(mon_w.addr));
        chk("wr_data", 32'(a_mem_wdata), 32'(mon_w.data));
      end
    end
  end

  task automatic do_clear();
    int nwe;
    wr_t w;
    nwe = 0;
    for (int i = 0; i < 32; i++) begin
      w.addr = 5'(i);
      w.data = '0;
      exp_q.push_back(w);
    end
    for (int i = 0; i < 32; i++) begin
      #1;
      if (a_mem_we === 1'b1 && a_in_ready === 1'b0 && a_core_rst === 1'b1) nwe++;
      step();
    end
    #1;
    chk("clear_cycles", 32'(nwe), 32'd32);
    chk("clear_then_ready", 32'(a_in_ready), 32'd1);
  endtask

  task automatic do_load(input int n, input logic [23:0] base);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = base + 24'(i);
      a_in_last  = (i == n - 1);
      w.addr = 5'(BA + i);
      w.data = base + 24'(i);
      exp_q.push_back(w);
      step();
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic pulse_restart_a();
    a_restart = 1'b1;
    step();
    a_restart = 1'b0;
  endtask

  initial begin
    logic [12:0] vpat;
    int nv;
    int runc;
    wr_t w;

    vpat = 13'b1110111001101;
    nv = 0;
    for (int k = 0; k < 13; k++) begin
      tbl[k].v         = vpat[k];
      tbl[k].d         = 24'h5A0000 + 24'(k * 24'h111);
      tbl[k].l         = (vpat[k] && nv == 8);
      tbl[k].exp_ready = 1'b1;
      tbl[k].exp_lc    = 6'(nv);
      if (vpat[k]) nv++;
    end

    step();
    step();
    #1;
    chk("rst_core_rst", 32'(a_core_rst), 32'd1);
    chk("rst_core_run", 32'(a_core_run), 32'd0);
    chk("rst_flags", {29'd0, a_done, a_timeout, a_load_ovf}, 32'd0);
    chk("rst_cycles", a_cycles, 32'd0);
    chk("rst_load_count", 32'(a_load_count), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_mem_we", 32'(a_mem_we), 32'd0);
    mon_en  = 1'b1;
    a_reset = 1'b0;
    do_clear();

    nv = 0;
    for (int k = 0; k < 13; k++) begin
      a_in_valid = tbl[k].v;
      a_in_data  = tbl[k].d;
      a_in_last  = tbl[k].l;
      if (tbl[k].v) begin
        w.addr = 5'(BA + nv);
        w.data = tbl[k].d;
        exp_q.push_back(w);
        nv++;
      end
      #1;
      chk("ld_ready", 32'(a_in_ready), 32'(tbl[k].exp_ready));
      chk("ld_core_rst", 32'(a_core_rst), 32'd1);
      chk("ld_count", 32'(a_load_count), 32'(tbl[k].exp_lc));
      step();
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    #1;
    chk("ld_final_count", 32'(a_load_count), 32'd9);
    chk("run_core_rst", 32'(a_core_rst), 32'd0);
    chk("run_core_run", 32'(a_core_run), 32'd1);
    chk("run_in_ready", 32'(a_in_ready), 32'd0);
    chk("run_cycles0", a_cycles, 32'd0);

    repeat (6) step();
    #1;
    chk("run_cycles6", a_cycles, 32'd6);
    a_halt_in = 1'b1;
    step();
    a_halt_in = 1'b0;
    #1;
    chk("halt_done", 32'(a_done), 32'd1);
    chk("halt_cycles", a_cycles, 32'd7);
    chk("halt_core_run", 32'(a_core_run), 32'd0);
    chk("halt_timeout", 32'(a_timeout), 32'd0);
    repeat (3) step();
    a_in_valid = 1'b1;
    a_in_data  = 24'hDEAD00;
    #1;
    chk("done_no_ready", 32'(a_in_ready), 32'd0);
    chk("done_held", 32'(a_done), 32'd1);
    chk("done_cycles_held", a_cycles, 32'd7);
    step();
    a_in_valid = 1'b0;

    pulse_restart_a();
    #1;
    chk("rs_done_clr", 32'(a_done), 32'd0);
    chk("rs_counts_clr", a_cycles + 32'(a_load_count), 32'd0);
    chk("rs_core_rst", 32'(a_core_rst), 32'd1);
    do_clear();
    do_load(3, 24'h100000);
    runc = 0;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (a_timeout === 1'b1) break;
      if (a_core_run === 1'b1) runc++;
      step();
    end
    chk("to_run_cycles", 32'(runc), 32'd100);
    chk("to_timeout", 32'(a_timeout), 32'd1);
    chk("to_cycles", a_cycles, 32'd100);
    chk("to_done", 32'(a_done), 32'd0);
    chk("to_core_run", 32'(a_core_run), 32'd0);

    pulse_restart_a();
    do_clear();
    do_load(2, 24'h200000);
    repeat (99) step();
    #1;
    chk("tie_cycles99", a_cycles, 32'd99);
    chk("tie_pre_timeout", 32'(a_timeout), 32'd0);
    a_halt_in = 1'b1;
    step();
    a_halt_in = 1'b0;
    #1;
    chk("tie_done", 32'(a_done), 32'd1);
    chk("tie_timeout", 32'(a_timeout), 32'd0);
    chk("tie_cycles", a_cycles, 32'd100);

    pulse_restart_a();
    do_clear();
    a_in_valid = 1'b1;
    a_in_data  = 24'h3C3C3C;
    a_restart  = 1'b1;
    w.addr = 5'(BA);
    w.data = 24'h3C3C3C;
    exp_q.push_back(w);
    step();
    a_in_valid = 1'b0;
    a_restart  = 1'b0;
    #1;
    chk("rs_hs_count", 32'(a_load_count), 32'd0);
    chk("rs_hs_in_clear", 32'(a_in_ready), 32'd0);
    do_clear();

    do_load(4, 24'h400000);
    repeat (5) step();
    #1;
    chk("mid_run_cycles", a_cycles, 32'd5);
    pulse_restart_a();
    #1;
    chk("mid_run_rs_cycles", a_cycles, 32'd0);
    chk("mid_run_rs_core_run", 32'(a_core_run), 32'd0);
    chk("mid_run_rs_core_rst", 32'(a_core_rst), 32'd1);
    do_clear();

    a_in_valid = 1'b1;
    a_in_data  = 24'h777777;
    a_reset    = 1'b1;
    #1;
    chk("rst_ld_no_we", 32'(a_mem_we), 32'd0);
    chk("rst_ld_no_ready", 32'(a_in_ready), 32'd0);
    step();
    a_in_valid = 1'b0;
    a_reset    = 1'b0;
    #1;
    chk("rst_ld_count", 32'(a_load_count), 32'd0);
    chk("rst_ld_core_rst", 32'(a_core_rst), 32'd1);
    do_clear();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    b_reset = 1'b0;
    #1;
    chk("b_load_first", 32'(b_in_ready), 32'd1);
    chk("b_core_rst", 32'(b_core_rst), 32'd1);
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 24'h0B0000 + 24'(i);
      b_in_last  = 1'b0;
      #1;
      chk("b_we", 32'(b_mem_we), 32'd1);
      chk("b_addr", 32'(b_mem_addr), 32'(i));
      chk("b_wdata", 32'(b_mem_wdata), 32'(24'h0B0000 + 24'(i)));
      step();
    end
    b_in_data = 24'h0B0008;
    #1;
    chk("b_ovf", 32'(b_load_ovf), 32'd1);
    chk("b_run", 32'(b_core_run), 32'd1);
    chk("b_no_ready", 32'(b_in_ready), 32'd0);
    chk("b_no_9th_we", 32'(b_mem_we), 32'd0);
    step();
    #1;
    chk("b_count", 32'(b_load_count), 32'd8);
    b_in_valid = 1'b0;
    b_restart  = 1'b1;
    step();
    b_restart = 1'b0;
    #1;
    chk("b_rs_ovf", 32'(b_load_ovf), 32'd0);
    chk("b_rs_load", 32'(b_in_ready), 32'd1);
    chk("b_rs_count", 32'(b_load_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
